// File: rtl/mux_stream_rr.sv
// N-channel streaming mux with registered output stage.
// Fixed-select or round-robin arbitration, valid/ready on all sides.
module mux_stream_rr #(
   parameter int CH = 8,
   parameter int W  = 8,
   parameter int SW = $clog2(CH)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   input  logic [CH*W-1:0] in_data,
   input  logic [CH-1:0]   in_valid,
   output logic [CH-1:0]   in_ready,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_ch,
   output logic            out_valid,
   input  logic            out_ready
);

   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_ch_q, out_ch_d;
   logic          out_valid_q, out_valid_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic          sel_ok;
   logic          rr_found;
   logic [SW-1:0] rr_ch;
   logic          grant_ok;
   logic [SW-1:0] grant_ch;
   logic          load;
   logic          xfer;

   // sel can only exceed the channel count when CH is not a power of two
   if (CH == (1 << SW)) begin : g_sel_full
      assign sel_ok = 1'b1;
   end else begin : g_sel_part
      assign sel_ok = int'(sel) < CH;
   end

   always_comb begin
      int idx;
      rr_found = 1'b0;
      rr_ch    = '0;
      idx      = 0;
      for (int i = 1; i <= CH; i++) begin
         idx = (int'(ptr_q) + i) % CH;
         if (!rr_found && in_valid[idx]) begin
            rr_found = 1'b1;
            rr_ch    = SW'(idx);
         end
      end
   end

   always_comb begin
      grant_ok = 1'b0;
      grant_ch = sel;
      if (mode) begin
         grant_ok = rr_found;
         grant_ch = rr_ch;
      end else if (sel_ok) begin
         grant_ok = in_valid[sel];
      end
   end

   assign load     = !out_valid_q || out_ready;
   assign xfer     = reset_n && load && grant_ok;
   assign in_ready = xfer ? (CH'(1) << grant_ch) : '0;

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = in_data[int'(grant_ch)*W +: W];
         out_ch_d    = grant_ch;
         out_valid_d = 1'b1;
         if (mode) ptr_d = grant_ch;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= SW'(CH-1);
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed bench for mux_stream_rr: 8-channel and 5-channel instances.
module tb_mux_stream_rr;

   logic        clk;
   logic        reset_n;

   logic        mode;
   logic [2:0]  sel;
   logic [63:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic        mode5;
   logic [2:0]  sel5;
   logic [39:0] in_data5;
   logic [4:0]  in_valid5;
   logic [4:0]  in_ready5;
   logic [7:0]  out_data5;
   logic [2:0]  out_ch5;
   logic        out_valid5;
   logic        out_ready5;

   int checks;
   int failures;

   mux_stream_rr #(.CH(8), .W(8)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   mux_stream_rr #(.CH(5), .W(8)) u_dut5 (
      .clk(clk), .reset_n(reset_n), .mode(mode5), .sel(sel5),
      .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
      .out_data(out_data5), .out_ch(out_ch5), .out_valid(out_valid5),
      .out_ready(out_ready5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset_n    = 1'b0;
      mode       = 1'b0;
      sel        = 3'd0;
      in_data    = '0;
      in_valid   = 8'hFF;
      out_ready  = 1'b0;
      mode5      = 1'b0;
      sel5       = 3'd0;
      in_data5   = '0;
      in_valid5  = '0;
      out_ready5 = 1'b0;

      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ch", 32'(out_ch), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'h0);

      reset_n = 1'b1;
      for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'hA0 + 8'(k);
      sel       = 3'd3;
      out_ready = 1'b1;
      #1;
      chk("fix_ready", 32'(in_ready), 32'h08);
      tick();
      chk("fix_data", 32'(out_data), 32'hA3);
      chk("fix_ch", 32'(out_ch), 32'd3);
      chk("fix_valid", 32'(out_valid), 32'd1);
      chk("fix_ready2", 32'(in_ready), 32'h08);
      in_data[24 +: 8] = 8'hB3;
      tick();
      chk("fix_tput", 32'(out_data), 32'hB3);
      in_data[24 +: 8] = 8'h5A;
      tick();
      chk("pre_rst_data", 32'(out_data), 32'h5A);

      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_ch", 32'(out_ch), 32'd0);
      tick();
      reset_n = 1'b1;
      mode    = 1'b1;
      for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
      #1;
      chk("rr_first", 32'(in_ready), 32'h01);

      for (int i = 0; i < 16; i++) begin
         tick();
         chk("rr_ch", 32'(out_ch), 32'(i % 8));
         chk("rr_data", 32'(out_data), 32'h10 + 32'(i % 8));
      end

      in_valid = 8'b0000_0100;
      tick();
      chk("sp_ch2", 32'(out_ch), 32'd2);
      in_valid = 8'b1000_0100;
      #1;
      chk("sp_ready7", 32'(in_ready), 32'h80);
      tick();
      chk("sp_ch7", 32'(out_ch), 32'd7);
      tick();
      chk("sp_wrap2", 32'(out_ch), 32'd2);
      in_valid = 8'b0000_0100;
      tick();
      chk("sp_only2a", 32'(out_ch), 32'd2);
      tick();
      chk("sp_only2b", 32'(out_ch), 32'd2);
      chk("sp_only2v", 32'(out_valid), 32'd1);

      in_valid  = 8'hFF;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ready", 32'(in_ready), 32'h0);
         chk("bp_data", 32'(out_data), 32'h12);
         chk("bp_valid", 32'(out_valid), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_ready", 32'(in_ready), 32'h08);
      tick();
      chk("bp_rel_valid", 32'(out_valid), 32'd1);
      chk("bp_rel_ch", 32'(out_ch), 32'd3);
      chk("bp_rel_data", 32'(out_data), 32'h13);
      in_valid = 8'h00;
      tick();
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_data", 32'(out_data), 32'h13);

      for (int k = 0; k < 5; k++) in_data5[k*8 +: 8] = 8'h50 + 8'(k);
      sel5       = 3'd6;
      in_valid5  = 5'h1F;
      out_ready5 = 1'b1;
      #1;
      chk("c5_oor_ready", 32'(in_ready5), 32'h0);
      tick();
      chk("c5_oor_valid", 32'(out_valid5), 32'd0);
      tick();
      chk("c5_oor_valid2", 32'(out_valid5), 32'd0);
      mode5 = 1'b1;
      #1;
      chk("c5_rr_ready", 32'(in_ready5), 32'h01);
      tick();
      chk("c5_rr_ch", 32'(out_ch5), 32'd0);
      chk("c5_rr_data", 32'(out_data5), 32'h50);
      chk("c5_rr_valid", 32'(out_valid5), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised N-channel, W-bit streaming multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Two run-time modes:
  - fixed-select: channel chosen by `sel`.
  - round-robin: fair rotation among channels with valid data.
- Sits between several producer streams and one shared consumer, for example a shared bus, UART TX or FIFO write port.

Parameters:
- CH, 8, number of input channels; legal range 2 or more, power of two not required.
- W, 8, data width per channel in bits.
- SW, $clog2(CH), width of channel index signals; derived, must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed-select, 1 = round-robin.
- sel  input  SW  channel selected in fixed-select mode; ignored in round-robin.
- in_data  input  CH*W  packed channel data; channel k occupies bits [k*W +: W].
- in_valid  input  CH  per-channel valid.
- in_ready  output  CH  per-channel ready; combinational.
- out_data  output  W  registered output data.
- out_ch  output  SW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer ptr = CH-1, so the first search starts at channel 0.
  - A beat held at reset is discarded; no in_ready is asserted while reset_n = 0.
- Load enable:
  - load = !out_valid || out_ready.
  - The output register can accept a new beat in the same cycle the current one drains, giving full throughput of 1 beat/cycle.
- Grant, combinational:
  - Fixed mode: grant exists iff sel < CH and in_valid[sel]; granted channel g = sel.
  - Round-robin mode: g is the first k with in_valid[k] set, searching ptr+1, ptr+2, ... modulo CH.
  - Round-robin search wraps from CH-1 to 0 and includes ptr itself last.
  - Grant exists iff any in_valid is set.
- in_ready[k] = load && grant_exists && (k == g). At most one in_ready is high per cycle; in_ready depends on in_valid, mode, sel, out_valid and out_ready.
- Transfer on channel g (in_valid[g] && in_ready[g]) at the clock edge:
  - out_data <= in_data[g*W +: W]
  - out_ch <= g
  - out_valid <= 1
  - In round-robin mode only, ptr <= g.
- Draining:
  - If out_valid && out_ready and no transfer occurs: out_valid <= 0; out_data and out_ch hold their last values.
  - If out_valid && !out_ready: out_data, out_ch and out_valid hold, and all in_ready are 0.
- Latency: 1 cycle from input handshake to out_valid.
- Ordering: beats from one channel leave in the order accepted; no beat is duplicated or dropped.
- Mode or sel change:
  - Takes effect on the grant in the same cycle.
  - A beat already in the output register is unaffected.
  - ptr is retained across fixed-mode periods.
- Fairness (round-robin): with all CH channels continuously valid and out_ready = 1, grants cycle 0, 1, …, CH-1, 0, … with no channel starved longer than CH-1 transfers.
- Out-of-range sel (sel ≥ CH, possible when CH is not a power of two): no grant, all in_ready = 0, no error flag.
- No combinational path from out_ready to out_data or out_valid.

Test Plan:
- Reset mid-stream, CH=8, W=8:
  - Stimulus: out_valid=1 with out_data=0x5A, then assert reset_n=0 between clock edges.
  - Required: out_valid, out_data and out_ch are 0 immediately, before the next edge.
  - Required: after release, the first round-robin grant goes to channel 0.
- Fixed mode, sel=3, in_data ch3=0xA3, in_valid=8'hFF, out_ready=1:
  - Required: in_ready=8'h08.
  - Required: next cycle out_data=0xA3, out_ch=3, out_valid=1; one beat per cycle sustained.
- Round-robin fairness, in_valid=8'hFF, out_ready=1 for 16 cycles, ch k data = 0x10+k:
  - Required: out_ch sequence 0,1,…,7,0,…,7.
  - Required: out_data sequence 0x10…0x17 repeated.
- Round-robin with sparse valid, in_valid=8'b1000_0100, ptr=2 after a grant to ch2:
  - Required: next grant ch7, then ch2 (wrap-around).
  - Required: with only ch2 valid, ch2 is granted on consecutive transfers.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1:
  - Required: all in_ready=0 and out_data stable.
  - On out_ready returning to 1: drain and new beat load in the same cycle, so out_valid stays 1 with no bubble.
- CH=5, fixed mode, sel=6, in_valid=5'h1F:
  - Required: in_ready=0 and out_valid stays 0.
  - Switching mode=1 then grants ch0 on the next cycle.
